dithered_pixel_reader: RTL and testbench
========================================

# dithered_pixel_reader

Read-side counterpart to the dithering engine. Once dithering has finished, this block scans the 8-bit pixel SRAM (`mem_block`) in raster order and thresholds each pixel to 1 bit. It packs 8 pixels per byte, MSB = leftmost pixel, and streams the bytes to the downstream transmitter over a valid/ready handshake. It owns one `mem_block` read port (port B) while busy.

## Interface
Parameters:
- IMAGEX, 64, image width in pixels; must be a multiple of 8 (elaboration-time check).
- IMAGEY, 64, image height in rows.
- IMAGE_SIZE, IMAGEX*IMAGEY, total pixel count.
- RGB_SIZE, 8, SRAM data width.
- BASE_ADDR, 0, SRAM address of pixel (0,0).
- RD_LATENCY, 2, cycles from a `rden` cycle to valid `q`; must be >= 1.

Ports (one clock; reset is synchronous and active-high):
- clk, input, 1, system clock (50 MHz).
- rst, input, 1, synchronous active-high reset.
- start, input, 1, one-cycle pulse that begins a scan; ignored while busy.
- busy, output, 1, high from the cycle after an accepted start until done.
- done, output, 1, one-cycle pulse after the final byte is accepted.
- sram_address, output, 16, SRAM port-B address.
- sram_rden, output, 1, SRAM port-B read enable.
- sram_q, input, RGB_SIZE, SRAM port-B read data.
- out_data, output, 8, packed pixel byte.
- out_valid, output, 1, out_data is valid.
- out_ready, input, 1, consumer accepts the byte this cycle.
- out_last_row, output, 1, qualifies out_data; the byte completes a row.
- out_eof, output, 1, qualifies out_data; final byte of the image.

## Operation
- Reset values: busy=0, done=0, sram_rden=0, sram_address=0, out_data=0, out_valid=0, out_last_row=0, out_eof=0. Internal pixel index=0, bit count=0, output buffer empty.
- The FSM has five states.
  - IDLE: when start=1, clear the pixel index and bit count and go to ISSUE.
  - ISSUE: drive sram_rden=1 and sram_address=BASE_ADDR+idx for exactly one cycle, then go to WAIT. The latency counter loads RD_LATENCY.
  - WAIT: decrement the counter. In the cycle the counter reaches 1, sram_q is valid. In that cycle, shift in bit (sram_q >= 128) and increment idx. If the bit count becomes 8, go to PUSH; otherwise go to ISSUE.
  - PUSH: if the output buffer is empty, or is being accepted this cycle (out_valid & out_ready), load the shift register into the buffer and set its flags. out_last_row is set when idx mod IMAGEX == 0; out_eof is set when idx == IMAGE_SIZE. Then go to ISSUE, or to DRAIN if idx == IMAGE_SIZE. If the buffer is not free, stay in PUSH.
  - DRAIN: wait until the buffer is empty, pulse done for one cycle, then go to IDLE.
- Handshake rules:
  - out_valid, once asserted, stays high with out_data and the flags stable until out_ready=1.
  - out_valid never depends combinationally on out_ready.
- Fetching continues while a byte waits in the output buffer. The scan stalls only when a second byte is packed and the buffer is still full.
- Arithmetic and widths:
  - idx is $clog2(IMAGE_SIZE)+1 bits wide so it can reach IMAGE_SIZE.
  - The address is zero-extended to 16 bits before BASE_ADDR is added.
  - The threshold compare is unsigned.
- sram_rden is never asserted outside ISSUE. The block never writes the SRAM.
- A start pulse in any state other than IDLE is ignored.
- Reset mid-scan: all state returns to reset values in the next cycle, any buffered byte is discarded, and done is not pulsed.

## Timing
- Each pixel takes 1+RD_LATENCY cycles; each byte adds 1 PUSH cycle when the buffer is free.
- Byte period is 8*(1+RD_LATENCY)+1 cycles, which is 25 at default parameters.
- First out_valid rises 1 (IDLE) + 8*(1+RD_LATENCY) + 1 cycles after the start cycle, i.e. cycle 26 at defaults.
- Full 64x64 scan with out_ready tied high: 512 bytes, done 12802 +/- 1 cycles after start.
- done asserts the cycle after the eof byte handshake (via DRAIN).

## Structure
- Shared package `dither_pkg` holds:
  - the reader state enum (IDLE, ISSUE, WAIT, PUSH, DRAIN);
  - the 128 threshold constant, shared with the closest-colour logic in the dithering engine;
  - the default image dimension constants.
- Sub-module `pixel_out_buffer` is the single-entry output register with valid/ready and the out_last_row/out_eof flags. The FSM, counters and shift register stay in the top.

## Test plan
- SRAM preloaded all 0xFF, out_ready=1, start pulse: 512 bytes of 0xFF are emitted. out_last_row fires on every 8th byte, out_eof only on byte 511, then one done pulse.
- Pixels 0..7 = 0x00, 0x80, 0x7F, 0xFF, 0x00, 0x00, 0x01, 0x90: the first byte is 0x51, and the first out_valid appears at cycle 26 after start.
- out_ready held low for 100 cycles after the first valid: out_data stays 0x51 and stable. The scan fetches the second byte and stalls in PUSH with sram_rden=0. On release, bytes arrive in order with none lost.
- rst asserted while the scan is at byte 200 and out_valid=1: the next cycle shows every output at its reset value. done never pulses. A new start restarts from address BASE_ADDR.
- start pulsed again at byte 10: ignored, and the byte sequence and total count (512) are unchanged.
- BASE_ADDR=4096, RD_LATENCY=1: sram_address spans 4096..8191, and the byte period is 17 cycles.

Source files
------------

// File: rtl/dither_pkg.sv
// Constants and encodings shared between the dithering engine and its read-side scanner.
package dither_pkg;
    localparam int DITHER_IMAGEX    = 64;
    localparam int DITHER_IMAGEY    = 64;
    // Mid-grey split: closest-colour picks white at or above this level.
    localparam int DITHER_THRESHOLD = 128;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        PUSH,
        DRAIN
    } rd_state_e;
endpackage

// File: rtl/dithered_pixel_reader_if.sv
// Control, SRAM port-B and packed-byte stream signals of the dithered pixel reader.
interface dithered_pixel_reader_if #(
    parameter int RGB_SIZE = 8
);
    logic                start;
    logic                busy;
    logic                done;
    logic [15:0]         sram_address;
    logic                sram_rden;
    logic [RGB_SIZE-1:0] sram_q;
    logic [7:0]          out_data;
    logic                out_valid;
    logic                out_ready;
    logic                out_last_row;
    logic                out_eof;

    modport master (
        input  start, sram_q, out_ready,
        output busy, done, sram_address, sram_rden,
        output out_data, out_valid, out_last_row, out_eof
    );

    modport slave (
        output start, sram_q, out_ready,
        input  busy, done, sram_address, sram_rden,
        input  out_data, out_valid, out_last_row, out_eof
    );
endinterface

// File: rtl/pixel_out_buffer.sv
// Single-entry output register holding one packed byte and its row/frame flags until accepted.
module pixel_out_buffer (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [7:0] i_data,
    input  logic       i_last_row,
    input  logic       i_eof,
    input  logic       i_ready,
    output logic       o_free,
    output logic       o_valid,
    output logic [7:0] o_data,
    output logic       o_last_row,
    output logic       o_eof
);
    logic       r_valid;
    logic [7:0] r_data;
    logic       r_last_row;
    logic       r_eof;

    // Free also while draining, so a byte can be reloaded without a bubble; o_valid stays registered.
    assign o_free     = !r_valid || i_ready;
    assign o_valid    = r_valid;
    assign o_data     = r_data;
    assign o_last_row = r_last_row;
    assign o_eof      = r_eof;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_last_row <= 1'b0;
            r_eof      <= 1'b0;
        end else if (i_load) begin
            r_valid    <= 1'b1;
            r_data     <= i_data;
            r_last_row <= i_last_row;
            r_eof      <= i_eof;
        end else if (r_valid && i_ready) begin
            r_valid    <= 1'b0;
        end
    end
endmodule

// File: rtl/dithered_pixel_reader.sv
// Raster scan of the pixel SRAM after dithering: threshold each pixel to 1 bit, pack 8 per
// byte (MSB = leftmost pixel) and stream the bytes out over valid/ready.
module dithered_pixel_reader
    import dither_pkg::*;
#(
    parameter int IMAGEX     = DITHER_IMAGEX,
    parameter int IMAGEY     = DITHER_IMAGEY,
    parameter int IMAGE_SIZE = IMAGEX * IMAGEY,
    parameter int RGB_SIZE   = 8,
    parameter int BASE_ADDR  = 0,
    parameter int RD_LATENCY = 2
) (
    input logic                     clk,
    input logic                     rst,
    dithered_pixel_reader_if.master bus
);
    localparam int IDX_W = $clog2(IMAGE_SIZE) + 1;
    localparam int LAT_W = (RD_LATENCY < 2) ? 1 : $clog2(RD_LATENCY + 1);

    if (IMAGEX % 8 != 0) begin : g_chk_imagex
        $error("dithered_pixel_reader: IMAGEX must be a multiple of 8");
    end
    if (RD_LATENCY < 1) begin : g_chk_latency
        $error("dithered_pixel_reader: RD_LATENCY must be at least 1");
    end
    if (IMAGE_SIZE != IMAGEX * IMAGEY) begin : g_chk_size
        $error("dithered_pixel_reader: IMAGE_SIZE must equal IMAGEX*IMAGEY");
    end
    if (RGB_SIZE < 8) begin : g_chk_rgb
        $error("dithered_pixel_reader: RGB_SIZE must hold the 128 threshold");
    end

    rd_state_e        r_state, w_next;
    logic [IDX_W-1:0] r_idx;
    logic [2:0]       r_bitcnt;
    logic [7:0]       r_shift;
    logic [LAT_W-1:0] r_lat;

    logic w_capture, w_load, w_buf_free, w_valid;
    logic w_bit, w_last_row, w_eof;

    assign w_bit      = bus.sram_q >= RGB_SIZE'(DITHER_THRESHOLD);
    // idx has already advanced past the byte's last pixel when these are evaluated in PUSH.
    assign w_last_row = (int'(r_idx) % IMAGEX) == 0;
    assign w_eof      = int'(r_idx) == IMAGE_SIZE;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_load    = 1'b0;
        case (r_state)
            IDLE:    if (bus.start) w_next = ISSUE;
            ISSUE:   w_next = WAIT;
            WAIT: begin
                if (r_lat == LAT_W'(1)) begin
                    w_capture = 1'b1;
                    w_next    = (r_bitcnt == 3'd7) ? PUSH : ISSUE;
                end
            end
            PUSH: begin
                if (w_buf_free) begin
                    w_load = 1'b1;
                    w_next = w_eof ? DRAIN : ISSUE;
                end
            end
            DRAIN:   if (!w_valid) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx    <= '0;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_lat    <= '0;
        end else begin
            if (r_state == IDLE && bus.start) begin
                r_idx    <= '0;
                r_bitcnt <= '0;
            end
            if (r_state == ISSUE)     r_lat <= LAT_W'(RD_LATENCY);
            else if (r_state == WAIT) r_lat <= r_lat - LAT_W'(1);
            // bit count wraps 7 -> 0 on the eighth pixel, ready for the next byte
            if (w_capture) begin
                r_shift  <= {r_shift[6:0], w_bit};
                r_idx    <= r_idx + IDX_W'(1);
                r_bitcnt <= r_bitcnt + 3'd1;
            end
        end
    end

    pixel_out_buffer u_buf (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_data     (r_shift),
        .i_last_row (w_last_row),
        .i_eof      (w_eof),
        .i_ready    (bus.out_ready),
        .o_free     (w_buf_free),
        .o_valid    (w_valid),
        .o_data     (bus.out_data),
        .o_last_row (bus.out_last_row),
        .o_eof      (bus.out_eof)
    );

    assign bus.out_valid    = w_valid;
    assign bus.busy         = r_state != IDLE;
    assign bus.done         = (r_state == DRAIN) && !w_valid;
    assign bus.sram_rden    = r_state == ISSUE;
    assign bus.sram_address = (r_state == ISSUE) ? 16'(BASE_ADDR) + 16'(r_idx) : '0;
endmodule

// File: tb/tb_dithered_pixel_reader.sv
// Bench for dithered_pixel_reader: two instances (default, and BASE_ADDR=4096/RD_LATENCY=1)
// fed from one behavioural SRAM image, checked against a byte-level packing model.
module tb_dithered_pixel_reader;
    localparam int IMGX   = 64;
    localparam int IMGY   = 64;
    localparam int NPIX   = IMGX * IMGY;
    localparam int NBYTES = NPIX / 8;
    localparam int LAT0   = 2;
    localparam int LAT1   = 1;
    localparam int BASE1  = 4096;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dithered_pixel_reader_if #(.RGB_SIZE(8)) bus0 ();
    dithered_pixel_reader_if #(.RGB_SIZE(8)) bus1 ();

    dithered_pixel_reader #(
        .IMAGEX(IMGX), .IMAGEY(IMGY), .IMAGE_SIZE(NPIX), .RGB_SIZE(8),
        .BASE_ADDR(0), .RD_LATENCY(LAT0)
    ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    dithered_pixel_reader #(
        .IMAGEX(IMGX), .IMAGEY(IMGY), .IMAGE_SIZE(NPIX), .RGB_SIZE(8),
        .BASE_ADDR(BASE1), .RD_LATENCY(LAT1)
    ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    logic [7:0] mem [NPIX];
    int n_checks = 0;
    int n_errors = 0;

    // Behavioural SRAMs: data only for cycles that issued rden, garbage otherwise.
    logic [7:0]  q0_p0, q0_p1, q1_p0;
    logic [15:0] a1;
    assign a1 = bus1.sram_address - 16'(BASE1);
    always @(posedge clk) begin
        q0_p0 <= bus0.sram_rden ? mem[bus0.sram_address[11:0]] : 8'($urandom);
        q0_p1 <= q0_p0;
        q1_p0 <= bus1.sram_rden ? mem[a1[11:0]] : 8'($urandom);
    end
    assign bus0.sram_q = q0_p1;
    assign bus1.sram_q = q1_p0;

    logic [9:0] rx0 [$];
    logic [9:0] rx1 [$];
    int done0 = 0, done1 = 0, hsv0 = 0, rng0 = 0, rng1 = 0;
    int amin1 = 65536, amax1 = -1;
    logic       pv0 = 1'b0, pr0 = 1'b0;
    logic [9:0] pd0 = '0;
    always @(negedge clk) begin
        if (bus0.out_valid && bus0.out_ready) rx0.push_back({bus0.out_last_row, bus0.out_eof, bus0.out_data});
        if (bus1.out_valid && bus1.out_ready) rx1.push_back({bus1.out_last_row, bus1.out_eof, bus1.out_data});
        if (bus0.done) done0++;
        if (bus1.done) done1++;
        if (!rst && pv0 && !pr0 && !(bus0.out_valid && {bus0.out_last_row, bus0.out_eof, bus0.out_data} == pd0)) hsv0++;
        pv0 = bus0.out_valid && !rst;
        pr0 = bus0.out_ready;
        pd0 = {bus0.out_last_row, bus0.out_eof, bus0.out_data};
        if (bus0.sram_rden && int'(bus0.sram_address) >= NPIX) rng0++;
        if (bus1.sram_rden) begin
            if (int'(bus1.sram_address) < BASE1 || int'(bus1.sram_address) >= BASE1 + NPIX) rng1++;
            if (int'(bus1.sram_address) < amin1) amin1 = int'(bus1.sram_address);
            if (int'(bus1.sram_address) > amax1) amax1 = int'(bus1.sram_address);
        end
    end

    // Expected {last_row, eof, data} of byte b: pixel 8b+k thresholded into bit 7-k.
    function automatic logic [9:0] exp_byte(input int b);
        logic [7:0] v;
        for (int k = 0; k < 8; k++) v[7-k] = (mem[8*b+k] >= 8'd128);
        return {(((b + 1) * 8) % IMGX) == 0, b == NBYTES - 1, v};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random();
        for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
    endtask

    task automatic test_reset();
        logic [30:0] o0, o1;
        rst = 1'b1;
        bus0.start = 1'b0; bus0.out_ready = 1'b0;
        bus1.start = 1'b0; bus1.out_ready = 1'b0;
        repeat (3) step();
        o0 = {bus0.busy, bus0.done, bus0.sram_rden, bus0.sram_address, bus0.out_data, bus0.out_valid, bus0.out_last_row, bus0.out_eof};
        o1 = {bus1.busy, bus1.done, bus1.sram_rden, bus1.sram_address, bus1.out_data, bus1.out_valid, bus1.out_last_row, bus1.out_eof};
        n_checks++;
        if (o0 !== '0) begin n_errors++; $display("FAIL reset_outputs0: got %h, expected 0", o0); end
        n_checks++;
        if (o1 !== '0) begin n_errors++; $display("FAIL reset_outputs1: got %h, expected 0", o1); end
        rst = 1'b0;
        repeat (2) step();
        n_checks++;
        if ({bus0.busy, bus0.sram_rden, bus0.out_valid} !== 3'b000) begin
            n_errors++; $display("FAIL idle_after_reset: busy/rden/valid=%b, expected 000", {bus0.busy, bus0.sram_rden, bus0.out_valid});
        end
    endtask

    task automatic test_all_ff();
        int n, d, bad, first;
        logic [9:0] e;
        for (int i = 0; i < NPIX; i++) mem[i] = 8'hFF;
        bus0.out_ready = 1'b1;
        rx0.delete();
        d = done0;
        bus0.start = 1'b1; step(); bus0.start = 1'b0;
        n = 1;
        while (!bus0.done && n < 20000) begin step(); n++; end
        n_checks++;
        if (n < 12801 || n > 12803) begin n_errors++; $display("FAIL allff_done_cycle: got %0d, expected 12802 +/- 1", n); end
        step();
        n_checks++;
        if (done0 - d !== 1) begin n_errors++; $display("FAIL allff_done_pulses: got %0d, expected 1", done0 - d); end
        n_checks++;
        if (bus0.busy !== 1'b0) begin n_errors++; $display("FAIL allff_busy_after_done: got %b, expected 0", bus0.busy); end
        n_checks++;
        if (rx0.size() !== NBYTES) begin n_errors++; $display("FAIL allff_count: got %0d, expected %0d", rx0.size(), NBYTES); end
        bad = 0; first = 0;
        for (int b = 0; b < rx0.size() && b < NBYTES; b++) begin
            e = {b % 8 == 7, b == NBYTES - 1, 8'hFF};
            if (rx0[b] !== e) begin if (bad == 0) first = b; bad++; end
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++; e = {first % 8 == 7, first == NBYTES - 1, 8'hFF};
            $display("FAIL allff_bytes: %0d bad, first #%0d got %h, expected %h", bad, first, rx0[first], e);
        end
    endtask

    task automatic test_pattern_stall();
        int n, d, h, bad, nr, first;
        logic [63:0] pat;
        logic [9:0] e;
        fill_random();
        pat = 64'h00_80_7F_FF_00_00_01_90;
        for (int k = 0; k < 8; k++) mem[k] = pat[63-8*k -: 8];
        bus0.out_ready = 1'b0;
        rx0.delete();
        d = done0; h = hsv0;
        bus0.start = 1'b1; step(); bus0.start = 1'b0;
        n = 1;
        while (!bus0.out_valid && n < 200) begin step(); n++; end
        n_checks++;
        if (n !== 1 + 8 * (1 + LAT0) + 1) begin n_errors++; $display("FAIL first_valid_cycle: got %0d, expected %0d", n, 1 + 8 * (1 + LAT0) + 1); end
        n_checks++;
        if (bus0.out_data !== 8'h51) begin n_errors++; $display("FAIL first_byte: got %h, expected 51", bus0.out_data); end
        bad = 0; nr = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus0.sram_rden) nr++;
            if (!(bus0.out_valid === 1'b1 && bus0.out_data === 8'h51)) bad++;
            step();
        end
        n_checks++;
        if (bad != 0) begin n_errors++; $display("FAIL stall_hold: %0d unstable cycles, expected 0", bad); end
        n_checks++;
        if (nr !== 8) begin n_errors++; $display("FAIL stall_fetches: got %0d reads, expected 8", nr); end
        n = 0;
        while (!bus0.done && n < 40000) begin
            bus0.out_ready = ($urandom_range(0, 3) != 0);
            step(); n++;
        end
        bus0.out_ready = 1'b1;
        step();
        n_checks++;
        if (done0 - d !== 1) begin n_errors++; $display("FAIL pattern_done: got %0d pulses, expected 1", done0 - d); end
        n_checks++;
        if (rx0.size() !== NBYTES) begin n_errors++; $display("FAIL pattern_count: got %0d, expected %0d", rx0.size(), NBYTES); end
        bad = 0; first = 0;
        for (int b = 0; b < rx0.size() && b < NBYTES; b++) if (rx0[b] !== exp_byte(b)) begin if (bad == 0) first = b; bad++; end
        n_checks++;
        if (bad != 0) begin
            n_errors++; e = exp_byte(first);
            $display("FAIL pattern_bytes: %0d bad, first #%0d got %h, expected %h", bad, first, rx0[first], e);
        end
        n_checks++;
        if (hsv0 - h !== 0) begin n_errors++; $display("FAIL handshake_stable: got %0d violations, expected 0", hsv0 - h); end
    endtask

    task automatic test_reset_mid();
        int n, d, q;
        logic [30:0] o;
        logic [9:0] e;
        fill_random();
        bus0.out_ready = 1'b1;
        rx0.delete();
        d = done0;
        bus0.start = 1'b1; step(); bus0.start = 1'b0;
        n = 0;
        while (!(rx0.size() == 200 && bus0.out_valid) && n < 8000) begin step(); n++; end
        n_checks++;
        if (n >= 8000) begin n_errors++; $display("FAIL midreset_reach: timed out at byte %0d, expected byte 200", rx0.size()); end
        rst = 1'b1; bus0.out_ready = 1'b0;
        step();
        o = {bus0.busy, bus0.done, bus0.sram_rden, bus0.sram_address, bus0.out_data, bus0.out_valid, bus0.out_last_row, bus0.out_eof};
        n_checks++;
        if (o !== '0) begin n_errors++; $display("FAIL midreset_outputs: got %h, expected 0", o); end
        step();
        rst = 1'b0; bus0.out_ready = 1'b1;
        q = 0;
        for (int i = 0; i < 50; i++) begin if (bus0.out_valid || bus0.busy) q++; step(); end
        n_checks++;
        if (q != 0 || done0 != d) begin n_errors++; $display("FAIL midreset_quiet: %0d active cycles, %0d done pulses, expected 0 and 0", q, done0 - d); end
        bus0.start = 1'b1; step(); bus0.start = 1'b0;
        n = 1;
        while (!bus0.sram_rden && n < 20) begin step(); n++; end
        n_checks++;
        if (bus0.sram_address !== 16'd0 || n != 1) begin n_errors++; $display("FAIL restart_addr: got %0d at cycle %0d, expected 0 at cycle 1", bus0.sram_address, n); end
        while (!bus0.out_valid && n < 200) begin step(); n++; end
        e = exp_byte(0);
        n_checks++;
        if (bus0.out_data !== e[7:0]) begin n_errors++; $display("FAIL restart_first_byte: got %h, expected %h", bus0.out_data, e[7:0]); end
        rst = 1'b1; repeat (2) step(); rst = 1'b0; step();
    endtask

    task automatic test_start_ignored();
        int n, d, bad, first;
        logic [9:0] e;
        fill_random();
        bus0.out_ready = 1'b1;
        rx0.delete();
        d = done0;
        bus0.start = 1'b1; step(); bus0.start = 1'b0;
        n = 1;
        while (rx0.size() < 10 && n < 1000) begin step(); n++; end
        bus0.start = 1'b1; step(); n++; bus0.start = 1'b0;
        while (!bus0.done && n < 20000) begin step(); n++; end
        n_checks++;
        if (n < 12801 || n > 12803) begin n_errors++; $display("FAIL restart_ignored_done: got %0d, expected 12802 +/- 1", n); end
        step();
        n_checks++;
        if (done0 - d !== 1) begin n_errors++; $display("FAIL restart_ignored_pulses: got %0d, expected 1", done0 - d); end
        n_checks++;
        if (rx0.size() !== NBYTES) begin n_errors++; $display("FAIL restart_ignored_count: got %0d, expected %0d", rx0.size(), NBYTES); end
        bad = 0; first = 0;
        for (int b = 0; b < rx0.size() && b < NBYTES; b++) if (rx0[b] !== exp_byte(b)) begin if (bad == 0) first = b; bad++; end
        n_checks++;
        if (bad != 0) begin
            n_errors++; e = exp_byte(first);
            $display("FAIL restart_ignored_bytes: %0d bad, first #%0d got %h, expected %h", bad, first, rx0[first], e);
        end
        n_checks++;
        if (rng0 !== 0) begin n_errors++; $display("FAIL addr_range0: got %0d out-of-range reads, expected 0", rng0); end
    endtask

    task automatic test_base_latency();
        int n, v1, v2, d, bad, first;
        logic [9:0] e;
        fill_random();
        bus1.out_ready = 1'b1;
        rx1.delete();
        d = done1; amin1 = 65536; amax1 = -1;
        bus1.start = 1'b1; step(); bus1.start = 1'b0;
        n = 1;
        while (!bus1.out_valid && n < 200) begin step(); n++; end
        v1 = n;
        step(); n++;
        while (!bus1.out_valid && n < 400) begin step(); n++; end
        v2 = n;
        n_checks++;
        if (v1 !== 1 + 8 * (1 + LAT1) + 1) begin n_errors++; $display("FAIL lat1_first_valid: got %0d, expected %0d", v1, 1 + 8 * (1 + LAT1) + 1); end
        n_checks++;
        if (v2 - v1 !== 8 * (1 + LAT1) + 1) begin n_errors++; $display("FAIL lat1_byte_period: got %0d, expected %0d", v2 - v1, 8 * (1 + LAT1) + 1); end
        while (!bus1.done && n < 20000) begin step(); n++; end
        step();
        n_checks++;
        if (done1 - d !== 1) begin n_errors++; $display("FAIL lat1_done: got %0d pulses, expected 1", done1 - d); end
        n_checks++;
        if (rx1.size() !== NBYTES) begin n_errors++; $display("FAIL lat1_count: got %0d, expected %0d", rx1.size(), NBYTES); end
        bad = 0; first = 0;
        for (int b = 0; b < rx1.size() && b < NBYTES; b++) if (rx1[b] !== exp_byte(b)) begin if (bad == 0) first = b; bad++; end
        n_checks++;
        if (bad != 0) begin
            n_errors++; e = exp_byte(first);
            $display("FAIL lat1_bytes: %0d bad, first #%0d got %h, expected %h", bad, first, rx1[first], e);
        end
        n_checks++;
        if (amin1 !== BASE1 || amax1 !== BASE1 + NPIX - 1) begin
            n_errors++; $display("FAIL lat1_addr_span: got %0d..%0d, expected %0d..%0d", amin1, amax1, BASE1, BASE1 + NPIX - 1);
        end
        n_checks++;
        if (rng1 !== 0) begin n_errors++; $display("FAIL addr_range1: got %0d out-of-range reads, expected 0", rng1); end
    endtask

    initial begin
        test_reset();
        test_all_ff();
        test_pattern_stall();
        test_reset_mid();
        test_start_ignored();
        test_base_latency();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
